// File: rtl/alu.sv
// 64-bit integer arithmetic/shift execute stage with a registered 65-bit result.
// Bit 64 of the result holds the carry, borrow or overflow flag for the selected operation.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] value_a,
  input  logic [63:0] value_b,
  input  logic [3:0]  opcode,
  output logic [64:0] y
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_EXP = 4'b0101,
    OP_LSR = 4'b0110,
    OP_LSL = 4'b0111,
    OP_ASR = 4'b1000,
    OP_ASL = 4'b1001
  } op_e;

  op_e         op;
  logic [64:0] a_ext;
  logic [64:0] b_ext;
  logic        b_zero;
  logic        b_ge_64;
  logic        b_gt_64;
  logic [5:0]  sh6;
  logic [6:0]  sh7;

  logic [64:0] add_res;
  logic [64:0] sub_res;
  logic [64:0] mul_res;
  logic [63:0] quo;
  logic [63:0] rem;
  logic [63:0] lsr_res;
  logic [64:0] lsl_res;
  logic [63:0] asr_res;
  logic [63:0] asl_lo;
  logic [63:0] asl_back;
  logic        asl_ovf;
  logic [64:0] y_next;

  assign op    = op_e'(opcode);
  assign a_ext = {1'b0, value_a};
  assign b_ext = {1'b0, value_b};

  // The shift amount is the whole 64-bit operand, so range checks look at every bit.
  assign b_zero  = (value_b == 64'd0);
  assign b_ge_64 = (value_b >= 64'd64);
  assign b_gt_64 = (value_b > 64'd64);
  assign sh6     = value_b[5:0];
  assign sh7     = value_b[6:0];

  assign add_res = a_ext + b_ext;
  assign sub_res = a_ext - b_ext;
  // A 65x65 multiply kept at 65 bits is exactly the low 65 bits of the full product.
  assign mul_res = a_ext * b_ext;
  assign quo     = b_zero ? 64'd0 : value_a / value_b;
  assign rem     = b_zero ? 64'd0 : value_a % value_b;

  assign lsr_res = value_a >> sh6;
  assign lsl_res = a_ext << sh7;
  assign asr_res = $signed(value_a) >>> sh6;

  // Signed overflow on ASL: shifting the result back arithmetically must restore a.
  assign asl_lo   = value_a << sh6;
  assign asl_back = $signed(asl_lo) >>> sh6;
  assign asl_ovf  = (value_a != 64'd0) && (b_ge_64 || (asl_back != value_a));

  always_comb begin
    // NOTE: y_next gets a default before the case so no path leaves it unassigned (no latch).
    y_next = 65'd0;
    case (op)
      OP_ADD: y_next = add_res;
      OP_SUB: y_next = sub_res;
      OP_MUL: y_next = mul_res;
      OP_DIV: y_next = b_zero ? {65{1'b1}} : {1'b0, quo};
      OP_MOD: y_next = b_zero ? {1'b1, value_a} : {1'b0, rem};
      OP_EXP: y_next = 65'd0;
      OP_LSR: y_next = b_ge_64 ? 65'd0 : {1'b0, lsr_res};
      OP_LSL: y_next = b_gt_64 ? 65'd0 : lsl_res;
      OP_ASR: y_next = b_ge_64 ? {65{value_a[63]}} : {value_a[63], asr_res};
      OP_ASL: y_next = {asl_ovf, (b_ge_64 ? 64'd0 : asl_lo)};
      default: y_next = 65'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) y <= 65'd0;
    else        y <= y_next;
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu execute stage.
// Inputs change between edges; the result is sampled 1 time unit after each rising edge.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] value_a;
  logic [63:0] value_b;
  logic [3:0]  opcode;
  logic [64:0] y;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, MUL = 4'b0010, DIV = 4'b0011,
                         MOD = 4'b0100, EXP = 4'b0101, LSR = 4'b0110, LSL = 4'b0111,
                         ASR = 4'b1000, ASL = 4'b1001;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_a (value_a),
    .value_b (value_b),
    .opcode  (opcode),
    .y       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    value_a = a;
    value_b = b;
    opcode  = op;
  endtask

  // Drive one operation, clock it in, and check the registered result.
  task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] op, input logic [64:0] exp);
    drive(a, b, op);
    @(posedge clk);
    #1;
    check(tag, y, exp);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(64'd1, 64'd2, ADD);
    @(posedge clk);
    #1;
    check("preload_add", y, 65'd3);

    // Asynchronous reset between edges clears y immediately.
    rst_n = 1'b0;
    #1;
    check("reset_async", y, 65'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", y, 65'd0);

    // Release between edges: y must stay 0 until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'd1, 64'd16, ADD);
    #1;
    check("release_no_edge", y, 65'd0);
    @(posedge clk);
    #1;
    check("add_1_16", y, 65'd17);

    step("add_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ADD, 65'h1_0000_0000_0000_0000);
    step("sub_borrow", 64'd5, 64'd7, SUB, 65'h1_FFFF_FFFF_FFFF_FFFE);
    step("sub_no_borrow", 64'd7, 64'd5, SUB, 65'd2);
    step("mul_2e32_sq", 64'h1_0000_0000, 64'h1_0000_0000, MUL, 65'h1_0000_0000_0000_0000);
    step("mul_max_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL, 65'd1);

    step("div_100_7", 64'd100, 64'd7, DIV, 65'd14);
    step("mod_100_7", 64'd100, 64'd7, MOD, 65'd2);
    step("div_by_zero", 64'd100, 64'd0, DIV, {65{1'b1}});
    step("mod_by_zero", 64'd100, 64'd0, MOD, {1'b1, 64'd100});

    step("lsr_4", 64'h8000_0000_0000_0000, 64'd4, LSR, 65'h0_0800_0000_0000_0000);
    step("lsr_64", 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, LSR, 65'd0);
    step("lsr_no_trunc", 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, LSR, 65'd0);
    step("asr_4", 64'h8000_0000_0000_0000, 64'd4, ASR, 65'h1_F800_0000_0000_0000);
    step("asr_64_neg", 64'h8000_0000_0000_0000, 64'd64, ASR, {65{1'b1}});
    step("asr_huge_pos", 64'h7000_0000_0000_0000, 64'h8000_0000_0000_0000, ASR, 65'd0);

    step("lsl_0", 64'd5, 64'd0, LSL, 65'd5);
    step("lsl_64", 64'd1, 64'd64, LSL, 65'h1_0000_0000_0000_0000);
    step("lsl_65", 64'hFFFF_FFFF_FFFF_FFFF, 64'd65, LSL, 65'd0);
    step("lsl_no_trunc", 64'd1, 64'h80, LSL, 65'd0);

    step("asl_ovf", 64'h4000_0000_0000_0000, 64'd1, ASL, 65'h1_8000_0000_0000_0000);
    step("asl_neg_ok", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, ASL, 65'h0_FFFF_FFFF_FFFF_FFF8);
    step("asl_zero_big", 64'd0, 64'd100, ASL, 65'd0);
    step("asl_big_ovf", 64'd1, 64'd100, ASL, 65'h1_0000_0000_0000_0000);

    // Back-to-back issue: each result lands exactly one edge after its inputs.
    step("b2b_add", 64'd10, 64'd20, ADD, 65'd30);
    drive(64'd10, 64'd20, SUB);
    #1;
    check("b2b_hold_add", y, 65'd30);
    @(posedge clk);
    #1;
    check("b2b_sub", y, 65'h1_FFFF_FFFF_FFFF_FFF6);
    drive(64'd3, 64'd4, EXP);
    #1;
    check("b2b_hold_sub", y, 65'h1_FFFF_FFFF_FFFF_FFF6);
    @(posedge clk);
    #1;
    check("b2b_exp", y, 65'd0);
    step("b2b_op_1111", 64'd3, 64'd4, 4'b1111, 65'd0);
    step("op_1010", 64'd9, 64'd9, 4'b1010, 65'd0);

    // Reset mid-operation discards the pending result.
    drive(64'd40, 64'd2, ADD);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_discard", y, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset_add", 64'd40, 64'd2, ADD, 65'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 64-bit integer arithmetic/shift unit with a registered 65-bit result.
- Selects one of nine operations via a 4-bit opcode; bit 64 of the result carries the carry/borrow/flag information.
- Sits in the datapath as a single-cycle-latency execute stage; operands are sampled every clock with no handshake.

Parameters:
- none (widths fixed: operands 64, opcode 4, result 65)

Ports:
- clk      input   1   rising-edge clock
- rst_n    input   1   asynchronous active-low reset
- value_a  input   64  operand A (unsigned unless op is ASR/ASL)
- value_b  input   64  operand B / shift amount
- opcode   input   4   operation select
- y        output  65  registered result; y[64] = carry/borrow/flag

Behaviour:
- Reset:
  - rst_n low clears y to 0 immediately, independent of clk.
  - Release is synchronous to the next rising clk.
  - If reset is asserted mid-operation, any pending result is discarded.
- Latency and timing:
  - On each rising clk with rst_n high: y <= f(value_a, value_b, opcode).
  - Latency is exactly 1 cycle; a new operation may be issued every cycle.
  - The combinational core is fully evaluated within one cycle (no multicycle paths).
- Opcodes:
  - 0000 ADD: y = {1'b0,a} + {1'b0,b}; y[64] = carry out.
  - 0001 SUB: y = {1'b0,a} - {1'b0,b} modulo 2^65; y[64] = 1 iff a < b (borrow).
  - 0010 MUL: unsigned 128-bit product; y = low 65 bits of product.
  - 0011 DIV: y = {1'b0, a / b}, unsigned. b==0 -> y = all 65 bits set.
  - 0100 MOD: y = {1'b0, a % b}, unsigned. b==0 -> y = {1'b1, a}.
  - 0101 EXP: reserved/disabled; y = 0.
  - 0110 LSR: y = {1'b0, a >> b}. b >= 64 -> y = 0.
  - 0111 LSL: y = ({1'b0,a} << b) truncated to 65 bits, so y[64] = a[64-b] for 1<=b<=64. b==0 -> {1'b0,a}. b >= 65 -> y = 0.
  - 1000 ASR: y[63:0] = signed a >>> b; y[64] = a[63] (sign extension). b >= 64 -> all 65 bits = a[63].
  - 1001 ASL: y[63:0] = a << b (0 if b >= 64); y[64] = 1 iff signed overflow, i.e. the result is not equal to signed a * 2^b. a==0 never overflows; a nonzero with b >= 64 always overflows.
  - 1010-1111: y = 0.
- The shift amount is the full 64-bit value_b; no truncation to 6 bits.
- X/Z on inputs is not required to be handled.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> y = 0 immediately; hold reset and toggle clk -> y stays 0.
- Release rst_n; a=1, b=16, ADD; one clk -> y = 17. Then a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ADD -> y = 65'h1_0000_0000_0000_0000.
- SUB and MUL:
  - a=5, b=7, SUB -> y = 65'h1_FFFF_FFFF_FFFF_FFFE (y[64]=1).
  - a=2^32, b=2^32, MUL -> y = 65'h1_0000_0000_0000_0000 (low 65 bits of 2^64).
- DIV and MOD:
  - a=100, b=7, DIV -> y = 14; MOD -> y = 2.
  - b=0: DIV -> all 65 bits set; MOD with a=100 -> y = {1'b1, 64'd100}.
- Shifts:
  - a=64'h8000_0000_0000_0000, b=4: LSR -> 64'h0800_0000_0000_0000; ASR -> 65'h1_F800_0000_0000_0000.
  - a=1, b=64: LSL -> 65'h1_0000_0000_0000_0000.
  - a=64'h4000_0000_0000_0000, b=1: ASL -> y[63:0] = 64'h8000_0000_0000_0000, y[64] = 1.
- Back-to-back and reserved opcodes:
  - Issue ADD, SUB, 0101, 1111 on consecutive cycles -> each result appears exactly one clk later.
  - Opcodes 0101 and 1111 produce y = 0.
